// File: rtl/id_decode_pipe_pkg.sv
// Shared types for the instruction-decode pipeline stage.
//   - opcode constants (instr[15:12])
//   - id_state_t : decode FSM states
//   - id_dec_t   : registered decoded bundle handed to execute
package id_decode_pipe_pkg;

    localparam logic [3:0] OP_IN  = 4'h1;
    localparam logic [3:0] OP_WR  = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JN  = 4'h4;
    localparam logic [3:0] OP_JR  = 4'h5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        SKIP  = 2'd2
    } id_state_t;

    typedef struct packed {
        logic        in_ena;
        logic        off_rd_ena;
        logic        wr_ena;
        logic        off_wr_ena;
        logic        jmp;
        logic        alu_ena;
        logic [2:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [4:0]  mem_adr;
        logic [2:0]  off_adr;
        logic [3:0]  jkind;
        logic [11:0] cnt;
        logic [7:0]  alu;
        logic [3:0]  a1;
        logic [3:0]  a2;
    } id_dec_t;

endpackage

// File: rtl/id_decode_pipe_if.sv
// Fetch/decode/execute handshake bundle for id_decode_pipe.
//   master : instruction source + execute side (drives instr, valid, dec_rdy, flush)
//   slave  : the decode stage
interface id_decode_pipe_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0]          instr_i;
    logic                        instr_vld_i;
    logic                        instr_rdy_o;
    id_decode_pipe_pkg::id_dec_t dec_o;
    logic                        dec_vld_o;
    logic                        dec_rdy_i;
    logic                        flush_i;
    logic                        haz_o;

    modport master (
        output instr_i, instr_vld_i, dec_rdy_i, flush_i,
        input  instr_rdy_o, dec_o, dec_vld_o, haz_o
    );

    modport slave (
        input  instr_i, instr_vld_i, dec_rdy_i, flush_i,
        output instr_rdy_o, dec_o, dec_vld_o, haz_o
    );
endinterface

// File: rtl/id_decode_pipe_comb.sv
// Purely combinational opcode decode for id_decode_pipe.
// Ports:
//   instr : instruction bits [15:0]
//   dec   : decoded bundle; every field not owned by the opcode is zero
module id_decode_comb
    import id_decode_pipe_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic [15:0] instr,
    output id_dec_t     dec
);
    // Jump target is the low CNT_W bits, zero-extended to the 12-bit field.
    localparam logic [11:0] CNT_MASK = 12'((13'd1 << CNT_W) - 13'd1);

    logic [3:0] opcode;

    assign opcode = instr[15:12];

    always_comb begin
        dec = '0;
        case (opcode)
            OP_IN: begin
                dec.rd = instr[11:9];
                if (instr[8:5] == 4'd0) begin
                    dec.in_ena  = 1'b1;
                    dec.mem_adr = instr[4:0];
                end else begin
                    dec.off_rd_ena = 1'b1;
                    dec.rm         = instr[8:5];
                end
            end
            OP_WR: begin
                dec.wr_ena = 1'b1;
                dec.rs     = instr[11:8];
                if (instr[7:5] == 3'd0) begin
                    dec.mem_adr = instr[4:0];
                end else begin
                    dec.off_wr_ena = 1'b1;
                    dec.off_adr    = instr[7:5];
                end
            end
            OP_JMP, OP_JN, OP_JR: begin
                dec.jmp   = 1'b1;
                dec.jkind = opcode;
                dec.cnt   = instr[11:0] & CNT_MASK;
            end
            default: begin
                if (instr[15:11] != 5'd0) begin
                    dec.alu_ena = 1'b1;
                    dec.alu     = instr[15:8];
                    dec.a1      = instr[7:4];
                    dec.a2      = instr[3:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/id_decode_pipe.sv
// Instruction decode stage: one-cycle registered decode with valid/ready
// handshakes, jump shadow skipping, execute-side flush and (optionally) a
// load-use hazard scoreboard.
// Optional feature macro: ID_HAZARD_STALL_EN -- compiles the scoreboard and the
// STALL state; without it haz_o is tied low and the stage never stalls.
// Ports:
//   clk_i : clock, all state on rising edge
//   rst   : asynchronous reset, active high
//   bus   : id_decode_pipe_if.slave (instr/valid/ready in, dec bundle out,
//           flush in, haz out)
//
// state | meaning
// RUN   | normal decode, one instruction per handshake
// STALL | waiting for a pending IN destination to retire
// SKIP  | jump issued; next accepted instruction is discarded
module id_decode_pipe
    import id_decode_pipe_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int CNT_W    = 12,
    parameter int LOAD_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst,
    id_decode_pipe_if.slave bus
);
    id_state_t          state, state_nxt;
    id_dec_t            dec, dec_q;
    logic               dec_vld_q;
    logic               can_take, haz_det, rdy, accept, issue;
    logic [INSTR_W-1:0] instr;

    assign instr = bus.instr_i;

    id_decode_comb #(.CNT_W(CNT_W)) u_comb (
        .instr (instr[15:0]),
        .dec   (dec)
    );

    assign can_take = !dec_vld_q || bus.dec_rdy_i;
    // The cycle that detects a hazard already refuses the instruction so the
    // source never sees a handshake that the stage then ignores.
    assign rdy      = (state != STALL) && can_take && !haz_det;
    assign accept   = bus.instr_vld_i && rdy && !bus.flush_i;
    assign issue    = accept && (state == RUN);

`ifdef ID_HAZARD_STALL_EN
    localparam logic [2:0] LAT = 3'(LOAD_LAT);

    logic [3:0] pend_reg;
    logic [2:0] pend_cnt;
    logic       src_hit;

    always_comb begin
        src_hit = (dec.alu_ena && ((dec.a1 == pend_reg) || (dec.a2 == pend_reg)))
               || (dec.wr_ena && (dec.rs == pend_reg));
    end

    assign haz_det = (state == RUN) && bus.instr_vld_i && (pend_cnt != 3'd0) && src_hit;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            pend_reg <= '0;
            pend_cnt <= '0;
        end else if (bus.flush_i) begin
            pend_reg <= '0;
            pend_cnt <= '0;
        end else if (issue && dec.in_ena) begin
            pend_reg <= {1'b0, dec.rd};
            pend_cnt <= LAT;
        end else if (pend_cnt != 3'd0) begin
            pend_cnt <= pend_cnt - 3'd1;
        end
    end

    assign bus.haz_o = haz_det || (state == STALL);
`else
    assign haz_det   = 1'b0;
    assign bus.haz_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (bus.flush_i) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (haz_det)
                        state_nxt = STALL;
                    else if (issue && dec.jmp)
                        state_nxt = SKIP;
                end
`ifdef ID_HAZARD_STALL_EN
                // Leave once the counter is about to hit zero, so the waiting
                // instruction is re-examined the cycle the pending load retires.
                STALL: begin
                    if (pend_cnt <= 3'd1)
                        state_nxt = RUN;
                end
`endif
                SKIP: begin
                    if (accept)
                        state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
        end else if (bus.flush_i) begin
            dec_vld_q <= 1'b0;
        end else if (issue) begin
            dec_q     <= dec;
            dec_vld_q <= 1'b1;
        end else if (bus.dec_rdy_i) begin
            dec_vld_q <= 1'b0;
        end
    end

    assign bus.instr_rdy_o = rdy;
    assign bus.dec_o       = dec_q;
    assign bus.dec_vld_o   = dec_vld_q;

endmodule

// File: doc/id_decode_pipe.md
ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, 16, instruction width (minimum 16; decode uses bits [15:0]; upper bits ignored).
REQ-002 SHALL have parameter CNT_W, 12, jump-target width (maximum 12; zero-extended from instr[11:0]).
REQ-003 SHALL have parameter LOAD_LAT, 2, cycles an IN destination stays pending in the scoreboard (range 1..7).
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous reset, active-high.
REQ-006 SHALL have port instr_i  in  INSTR_W  fetched instruction.
REQ-007 SHALL have port instr_vld_i  in  1  instruction valid.
REQ-008 SHALL have port instr_rdy_o  out  1  decoder accepts instruction.
REQ-009 SHALL have port dec_o  out  id_dec_t  registered decoded bundle.
REQ-010 SHALL have port dec_vld_o  out  1  dec_o valid.
REQ-011 SHALL have port dec_rdy_i  in  1  execute stage accepts dec_o.
REQ-012 SHALL have port flush_i  in  1  squash from execute (taken branch).
REQ-013 SHALL have port haz_o  out  1  high while stalled on a hazard.

Function
REQ-014 SHALL accept an instruction when instr_vld_i & instr_rdy_o; dec_o/dec_vld_o update the following cycle (latency 1).
REQ-015 SHALL drive instr_rdy_o = (state != STALL) & (!dec_vld_o | dec_rdy_i).
REQ-016 SHALL hold dec_o stable while dec_vld_o & !dec_rdy_i.
REQ-017 SHALL decode OP_IN: instr[8:5]==0 -> in_ena=1, rd=instr[11:9], mem_adr=instr[4:0]; else off_rd_ena=1, rm=instr[8:5], rd=instr[11:9].
REQ-018 SHALL decode OP_WR: wr_ena=1, rs=instr[11:8]; instr[7:5]==0 -> mem_adr=instr[4:0]; else off_wr_ena=1, off_adr=instr[7:5].
REQ-019 SHALL decode OP_JMP/OP_JN/OP_JR: jmp=1, jkind=opcode, cnt=instr[11:0].
REQ-020 SHALL decode other opcodes: instr[15:11]!=0 -> alu_ena=1, alu=instr[15:8], a1=instr[7:4], a2=instr[3:0]; else NOP (all enables 0).
REQ-021 SHALL zero every dec_o field not assigned by the decoded opcode.
REQ-022 SHALL implement FSM RUN/STALL/SKIP: RUN normal; STALL hazard wait; SKIP after an issued jump.
REQ-023 SHALL record the destination (zero-extended to 4 bits) of each issued IN with a down-counter loaded to LAT = LOAD_LAT.
REQ-024 SHALL, in RUN, go to STALL when the incoming ALU a1/a2 or WR rs equals the pending register with counter != 0; no acceptance, haz_o=1, dec_vld_o=0 once the current output drains.
REQ-025 SHALL return STALL -> RUN the cycle after the counter reaches 0; a new IN issued the same cycle reloads the counter.
REQ-026 SHALL, after issuing a jump, enter SKIP: discard the next accepted instruction (no output), then RUN.
REQ-027 SHALL, on flush_i, clear dec_vld_o next cycle, clear the scoreboard, drop the same-cycle input, and go to RUN; flush_i beats stall, skip and handshake.

Reset
REQ-028 SHALL on rst: state=RUN, dec_vld_o=0, dec_o=0, haz_o=0, scoreboard counter=0, instr_rdy_o=1 the first cycle after release.
REQ-029 SHALL abort any stall or skip when rst asserts mid-operation; no partial output after release.

Configuration
REQ-030 SHALL compile the scoreboard and STALL state only under ID_HAZARD_STALL_EN.
REQ-031 SHALL, without ID_HAZARD_STALL_EN, tie haz_o=0, never enter STALL; all other behaviour unchanged.

Structure
REQ-032 SHALL take id_dec_t, state enum and opcodes OP_IN=4'h1, OP_WR=4'h2, OP_JMP=4'h3, OP_JN=4'h4, OP_JR=4'h5 from the shared package.
REQ-033 SHALL place the combinational opcode decode in one sub-module id_decode_comb; FSM, scoreboard and output register stay in id_decode_pipe.

Verification
REQ-034 SHALL test: instr 16'h1A05, dec_rdy_i=1 -> next cycle dec_vld_o=1, in_ena=1, rd=5, mem_adr=5.
REQ-035 SHALL test: 16'h1A05 then ALU 16'h8050 (a1=5), LOAD_LAT=2 -> haz_o=1 two cycles, ALU output two cycles late; macro off -> no stall.
REQ-036 SHALL test: 16'h3123 then 16'h8012 -> cnt=12'h123, jmp=1; 16'h8012 dropped; next instruction decoded.
REQ-037 SHALL test: dec_rdy_i=0 three cycles -> dec_o stable, instr_rdy_o=0; release -> one transfer.
REQ-038 SHALL test: flush_i during STALL -> dec_vld_o=0, haz_o=0 next cycle, new instruction accepted.
REQ-039 SHALL test: rst asserted in SKIP -> all outputs 0; first post-reset instruction decoded normally.
